// File: rtl/vend_payout_arbiter_pkg.sv
// rtl/vend_payout_arbiter_pkg.sv - payout state encoding, coin codes and coin values for the change arbiter
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_SELECT = 3'd2,
        ST_PULSE  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } pay_state_t;

    typedef enum logic [1:0] {
        COIN_NONE   = 2'd0,
        COIN_NICKEL = 2'd1,
        COIN_DIME   = 2'd2
    } coin_t;

    localparam int NICKEL_VAL = 1;
    localparam int DIME_VAL   = 2;
    localparam int STAT_W     = 16;
    localparam int FAULT_W    = 8;

    function automatic int coin_value(input coin_t c);
        case (c)
            COIN_DIME:   return DIME_VAL;
            COIN_NICKEL: return NICKEL_VAL;
            default:     return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_payout_arbiter_rr_arbiter.sv
// rtl/vend_payout_arbiter_rr_arbiter.sv - combinational round-robin pick: first set request at/after pointer
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Scan from farthest to nearest so the lane closest to the pointer is written last and wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_gnt                          = '0;
                o_gnt[(int'(i_ptr) + k) % N]   = 1'b1;
                o_idx                          = IW'((int'(i_ptr) + k) % N);
                o_valid                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_payout_arbiter.sv
// rtl/vend_payout_arbiter.sv - shares one dime/nickel payout mechanism among lanes; PAYOUT_STATS_EN adds counters
module vend_payout_arbiter
    import vend_pkg::*;
#(
    parameter int N_LANES   = 4,
    parameter int AMT_W     = 4,
    parameter int PULSE_CYC = 8,
    parameter int GAP_CYC   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_LANES-1:0]         req,
    input  logic [N_LANES*AMT_W-1:0]   amt,
    input  logic                       dime_empty,
    input  logic                       nickel_empty,
    output logic                       sol_dime,
    output logic                       sol_nickel,
    output logic                       busy,
    output logic [$clog2(N_LANES)-1:0] grant_id,
    output logic [N_LANES-1:0]         ack,
    output logic                       ack_err
`ifdef PAYOUT_STATS_EN
    ,
    output logic [STAT_W-1:0]          dimes_paid,
    output logic [STAT_W-1:0]          nickels_paid,
    output logic [FAULT_W-1:0]         faults
`endif
);

    localparam int IW      = $clog2(N_LANES);
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    pay_state_t          r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_grant_id;
    logic [AMT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sol_dime;
    logic                r_sol_nickel;
    logic [N_LANES-1:0]  r_ack;
    logic                r_ack_err;

    logic [N_LANES-1:0]  w_gnt;
    logic [IW-1:0]       w_idx;
    logic                w_valid;
    logic [AMT_W-1:0]    w_amt_sel;
    coin_t               w_coin;

    rr_arbiter #(.N(N_LANES), .IW(IW)) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_amt_sel = amt[w_idx*AMT_W +: AMT_W];

    // Coin choice for the current SELECT; hopper flags matter only in that state.
    always_comb begin
        w_coin = COIN_NONE;
        if (r_remaining >= AMT_W'(DIME_VAL) && !dime_empty)
            w_coin = COIN_DIME;
        else if (r_remaining >= AMT_W'(NICKEL_VAL) && !nickel_empty)
            w_coin = COIN_NICKEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_grant_id   <= '0;
            r_remaining  <= '0;
            r_cnt        <= '0;
            r_sol_dime   <= 1'b0;
            r_sol_nickel <= 1'b0;
            r_ack        <= '0;
            r_ack_err    <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) r_state <= ST_GRANT;
                end
                ST_GRANT: begin
                    if (w_valid) begin
                        r_grant_id  <= w_idx;
                        r_remaining <= w_amt_sel;
                        r_ptr       <= (w_idx == IW'(N_LANES - 1)) ? '0 : w_idx + IW'(1);
                        r_state     <= ST_SELECT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (r_remaining == '0 || w_coin == COIN_NONE) begin
                        // ack is registered here so it is high exactly during DONE
                        r_ack[r_grant_id] <= 1'b1;
                        r_ack_err         <= (r_remaining != '0);
                        r_state           <= ST_DONE;
                    end else begin
                        r_remaining  <= r_remaining - AMT_W'(coin_value(w_coin));
                        r_sol_dime   <= (w_coin == COIN_DIME);
                        r_sol_nickel <= (w_coin == COIN_NICKEL);
                        r_cnt        <= CNT_W'(PULSE_CYC - 1);
                        r_state      <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_sol_dime   <= 1'b0;
                        r_sol_nickel <= 1'b0;
                        r_cnt        <= CNT_W'(GAP_CYC - 1);
                        r_state      <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) r_state <= ST_SELECT;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sol_dime   = r_sol_dime;
    assign sol_nickel = r_sol_nickel;
    assign busy       = (r_state != ST_IDLE);
    assign grant_id   = r_grant_id;
    assign ack        = r_ack;
    assign ack_err    = r_ack_err;

`ifdef PAYOUT_STATS_EN
    logic [STAT_W-1:0]  r_dimes_paid;
    logic [STAT_W-1:0]  r_nickels_paid;
    logic [FAULT_W-1:0] r_faults;

    // Counters saturate rather than wrap so a long-running machine never reports a small count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dimes_paid   <= '0;
            r_nickels_paid <= '0;
            r_faults       <= '0;
        end else if (r_state == ST_SELECT && r_remaining != '0) begin
            if (w_coin == COIN_DIME && r_dimes_paid != '1)
                r_dimes_paid <= r_dimes_paid + STAT_W'(1);
            if (w_coin == COIN_NICKEL && r_nickels_paid != '1)
                r_nickels_paid <= r_nickels_paid + STAT_W'(1);
            if (w_coin == COIN_NONE && r_faults != '1)
                r_faults <= r_faults + FAULT_W'(1);
        end
    end

    assign dimes_paid   = r_dimes_paid;
    assign nickels_paid = r_nickels_paid;
    assign faults       = r_faults;
`endif

endmodule
